// File: rtl/csr_regfile.sv
// Machine-mode CSR register file for the RV32 core.
// Provides a combinational CSR read port, one committed write port, trap/mret updates and the hardware counters.
module csr_regfile #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_rd_addr,
  output logic [31:0] csr_rd_data,
  output logic        csr_illegal,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_wr_addr,
  input  logic [31:0] csr_wr_data,
  input  logic        inst_retire,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_en,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic [31:0] mip_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mscratch_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] mstatus_rd;
  logic [63:0] mcycle_inc;
  logic [63:0] minstret_inc;
  logic [31:0] irq_pend;
  logic [31:0] mtvec_base;
  logic        rd_impl;
  logic        wr_bad;

  function automatic logic is_impl(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH,
      A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: is_impl = 1'b1;
      default: is_impl = 1'b0;
    endcase
  endfunction

  function automatic logic is_ro(input logic [11:0] a);
    is_ro = (a == A_MVENDORID) || (a == A_MARCHID) || (a == A_MIMPID) || (a == A_MHARTID);
  endfunction

  // MPP is hard-wired to machine mode; only MIE and MPIE hold state.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      A_MSTATUS:   csr_rd_data = mstatus_rd;
      A_MISA:      csr_rd_data = MISA_VALUE;
      A_MIE:       csr_rd_data = mie_q;
      A_MTVEC:     csr_rd_data = mtvec_q;
      A_MSCRATCH:  csr_rd_data = mscratch_q;
      A_MEPC:      csr_rd_data = mepc_q;
      A_MCAUSE:    csr_rd_data = mcause_q;
      A_MTVAL:     csr_rd_data = mtval_q;
      A_MIP:       csr_rd_data = mip_q;
      A_MCYCLE:    csr_rd_data = mcycle_q[31:0];
      A_MCYCLEH:   csr_rd_data = mcycle_q[63:32];
      A_MINSTRET:  csr_rd_data = minstret_q[31:0];
      A_MINSTRETH: csr_rd_data = minstret_q[63:32];
      A_MHARTID:   csr_rd_data = HART_ID;
      default:     csr_rd_data = '0;
    endcase
  end

  assign rd_impl     = is_impl(csr_rd_addr);
  assign wr_bad      = csr_wr_en && (!is_impl(csr_wr_addr) || is_ro(csr_wr_addr));
  assign csr_illegal = !rd_impl || wr_bad;

  assign mcycle_inc   = mcycle_q + 64'd1;
  assign minstret_inc = minstret_q + {63'b0, inst_retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mscratch_q   <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
    end else begin
      mip_q <= {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};

      if (csr_wr_en && csr_wr_addr == A_MIE)      mie_q      <= csr_wr_data & MIE_MASK;
      if (csr_wr_en && csr_wr_addr == A_MSCRATCH) mscratch_q <= csr_wr_data;
      // Reserved modes 2/3 collapse to direct mode.
      if (csr_wr_en && csr_wr_addr == A_MTVEC)
        mtvec_q <= {csr_wr_data[31:2], csr_wr_data[1] ? 2'b00 : csr_wr_data[1:0]};

      if (trap_en) begin
        mepc_q       <= {trap_pc[31:2], 2'b00};
        mcause_q     <= trap_cause;
        mtval_q      <= trap_val;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (csr_wr_en && csr_wr_addr == A_MEPC)   mepc_q   <= {csr_wr_data[31:2], 2'b00};
        if (csr_wr_en && csr_wr_addr == A_MCAUSE) mcause_q <= csr_wr_data;
        if (csr_wr_en && csr_wr_addr == A_MTVAL)  mtval_q  <= csr_wr_data;
        if (mret_en) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (csr_wr_en && csr_wr_addr == A_MSTATUS) begin
          mstatus_mie  <= csr_wr_data[3];
          mstatus_mpie <= csr_wr_data[7];
        end
      end

      // A half-write replaces that half; a high-half write drops the low-half carry.
      if (csr_wr_en && csr_wr_addr == A_MCYCLE)
        mcycle_q[31:0] <= csr_wr_data;
      else if (csr_wr_en && csr_wr_addr == A_MCYCLEH)
        mcycle_q <= {csr_wr_data, mcycle_inc[31:0]};
      else
        mcycle_q <= mcycle_inc;

      if (csr_wr_en && csr_wr_addr == A_MINSTRET)
        minstret_q[31:0] <= csr_wr_data;
      else if (csr_wr_en && csr_wr_addr == A_MINSTRETH)
        minstret_q <= {csr_wr_data, minstret_inc[31:0]};
      else
        minstret_q <= minstret_inc;
    end
  end

  assign irq_pend = mip_q & mie_q;
  assign irq_req  = mstatus_mie && (|irq_pend);

  always_comb begin
    irq_cause = '0;
    if (irq_pend[11])     irq_cause = 32'h8000_000B;
    else if (irq_pend[3]) irq_cause = 32'h8000_0003;
    else if (irq_pend[7]) irq_cause = 32'h8000_0007;
  end

  assign mtvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_vector = mtvec_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause[31])
      trap_vector = mtvec_base + {25'b0, trap_cause[4:0], 2'b00};
  end

  assign mepc_out = mepc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: reset/counter sequence, a write/read vector table, trap/irq/counter corner
// sequences and a randomized run compared every cycle against an architectural model.
`timescale 1ns/1ps
module tb_csr_regfile;

  localparam logic [31:0] HART_ID     = 32'd3;
  localparam logic [31:0] MTVEC_RESET = 32'h0000_0080;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  logic        clk;
  logic        rst;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_illegal;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        inst_retire;
  logic        trap_en;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_en;
  logic        ext_irq;
  logic        timer_irq;
  logic        sw_irq;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;

  csr_regfile #(.HART_ID(HART_ID), .MTVEC_RESET(MTVEC_RESET), .MISA_VALUE(MISA_VALUE)) dut (
    .clk(clk), .rst(rst),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .inst_retire(inst_retire), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret_en(mret_en),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .irq_req(irq_req), .irq_cause(irq_cause), .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // architectural model
  bit          m_valid = 0;
  bit          m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [63:0] m_cycle, m_instret;

  function automatic bit m_impl(input logic [11:0] a);
    logic [11:0] lst[17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                             12'hF11, 12'hF12, 12'hF13, 12'hF14};
    foreach (lst[i]) if (lst[i] == a) return 1;
    return 0;
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a >= 12'hF11 && a <= 12'hF14;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (32'(m_mpie) * 128) + (32'(m_mie_b) * 8);
      12'h301: return MISA_VALUE;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF14: return HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq_cause();
    logic [31:0] p = m_mip & m_mie;
    if (p[11]) return 32'h8000_000B;
    if (p[3])  return 32'h8000_0003;
    if (p[7])  return 32'h8000_0007;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_vector();
    logic [31:0] base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'd1 && trap_cause[31]) return base + 4 * 32'(trap_cause[4:0]);
    return base;
  endfunction

  task automatic model_update();
    bit old_mie = m_mie_b;
    bit old_mpie = m_mpie;
    logic [63:0] cyc = m_cycle + 1;
    logic [63:0] ins = m_instret + 64'(inst_retire);
    if (rst) begin
      m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mip = 0; m_mtvec = MTVEC_RESET;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_cycle = 0; m_instret = 0;
      m_valid = 1;
      return;
    end
    m_mip = (ext_irq ? 32'h800 : 0) | (timer_irq ? 32'h80 : 0) | (sw_irq ? 32'h8 : 0);
    if (csr_wr_en && csr_wr_addr == 12'hB00)      cyc = {m_cycle[63:32], csr_wr_data};
    else if (csr_wr_en && csr_wr_addr == 12'hB80) cyc = {csr_wr_data, cyc[31:0]};
    if (csr_wr_en && csr_wr_addr == 12'hB02)      ins = {m_instret[63:32], csr_wr_data};
    else if (csr_wr_en && csr_wr_addr == 12'hB82) ins = {csr_wr_data, ins[31:0]};
    m_cycle = cyc;
    m_instret = ins;
    if (csr_wr_en) begin
      case (csr_wr_addr)
        12'h300: begin m_mie_b = csr_wr_data[3]; m_mpie = csr_wr_data[7]; end
        12'h304: m_mie = csr_wr_data & 32'h888;
        12'h305: m_mtvec = (csr_wr_data[1:0] >= 2) ? (csr_wr_data & ~32'h3) : csr_wr_data;
        12'h340: m_mscratch = csr_wr_data;
        12'h341: m_mepc = csr_wr_data & ~32'h3;
        12'h342: m_mcause = csr_wr_data;
        12'h343: m_mtval = csr_wr_data;
        default: ;
      endcase
    end
    if (mret_en) begin m_mie_b = old_mpie; m_mpie = 1; end
    if (trap_en) begin
      m_mpie = old_mie; m_mie_b = 0;
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
    end
  endtask

  // one clock: compare all outputs with the model, advance the model, cross the edge
  task automatic tick();
    #1;
    if (m_valid) begin
      chk("rd_data", csr_rd_data, m_read(csr_rd_addr));
      chk("illegal", 32'(csr_illegal), 32'(!m_impl(csr_rd_addr) ||
          (csr_wr_en && (!m_impl(csr_wr_addr) || m_ro(csr_wr_addr)))));
      chk("irq_req", 32'(irq_req), 32'(m_mie_b && ((m_mip & m_mie) != 0)));
      chk("irq_cause", irq_cause, m_irq_cause());
      chk("trap_vector", trap_vector, m_vector());
      chk("mepc_out", mepc_out, m_mepc);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_rd_addr = a;
    #1;
    chk(name, csr_rd_data, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en = 1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wr_en = 0;
  endtask

  typedef struct {
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] exp_rd;
    logic        exp_ill;
    logic        exp_wr_ill;
  } vec_t;

  vec_t vecs[14];
  logic [11:0] addr_pool[19];

  initial begin
    rst = 1; csr_rd_addr = 12'h300; csr_wr_en = 0; csr_wr_addr = 0; csr_wr_data = 0;
    inst_retire = 0; trap_en = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret_en = 0;
    ext_irq = 0; timer_irq = 0; sw_irq = 0;

    vecs[0]  = '{12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 0, 0};
    vecs[1]  = '{12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 0, 0};
    vecs[2]  = '{12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000, 0, 0};
    vecs[3]  = '{12'h341, 32'h1234_5677, 12'h341, 32'h1234_5674, 0, 0};
    vecs[4]  = '{12'h305, 32'h0000_0103, 12'h305, 32'h0000_0100, 0, 0};
    vecs[5]  = '{12'h305, 32'h0000_0102, 12'h305, 32'h0000_0100, 0, 0};
    vecs[6]  = '{12'h305, 32'h0000_0101, 12'h305, 32'h0000_0101, 0, 0};
    vecs[7]  = '{12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, 0, 0};
    vecs[8]  = '{12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 0, 0};
    vecs[9]  = '{12'hF14, 32'hFFFF_FFFF, 12'hF14, HART_ID,       0, 1};
    vecs[10] = '{12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, 0, 0};
    vecs[11] = '{12'h343, 32'hCAFE_F00D, 12'h343, 32'hCAFE_F00D, 0, 0};
    vecs[12] = '{12'h300, 32'h0000_0000, 12'h300, 32'h0000_1800, 0, 0};
    vecs[13] = '{12'h7C0, 32'h1111_1111, 12'h7C0, 32'h0000_0000, 1, 1};

    addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13,
                  12'hF14, 12'h7C0, 12'h345};

    // reset, then mcycle counts 0,1,2,3
    tick();
    rst = 0;
    rd_check("rst_mstatus", 12'h300, 32'h1800);
    rd_check("rst_mtvec", 12'h305, MTVEC_RESET);
    rd_check("rst_mcycleh", 12'hB80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_check("rst_mcycle", 12'hB00, 32'(i));
      tick();
    end

    // vector table
    foreach (vecs[i]) begin
      csr_wr_en = 1; csr_wr_addr = vecs[i].wa; csr_wr_data = vecs[i].wd; csr_rd_addr = vecs[i].ra;
      #1;
      chk("vec_wr_illegal", 32'(csr_illegal), 32'(vecs[i].exp_wr_ill));
      tick();
      csr_wr_en = 0;
      rd_check("vec_rd", vecs[i].ra, vecs[i].exp_rd);
      chk("vec_rd_illegal", 32'(csr_illegal), 32'(vecs[i].exp_ill));
    end

    // timer interrupt, vectored trap, mret
    wr(12'h305, 32'h101);
    wr(12'h300, 32'h8);
    timer_irq = 1;
    wr(12'h304, 32'h80);
    #1;
    chk("irq_req_set", 32'(irq_req), 32'h1);
    chk("irq_cause_mti", irq_cause, 32'h8000_0007);
    trap_en = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h206; trap_val = 32'h0;
    #1;
    chk("trap_vector", trap_vector, 32'h11C);
    tick();
    trap_en = 0; timer_irq = 0;
    rd_check("trap_mepc", 12'h341, 32'h204);
    rd_check("trap_mstatus", 12'h300, 32'h1880);
    chk("trap_irq_off", 32'(irq_req), 32'h0);
    mret_en = 1;
    tick();
    mret_en = 0;
    rd_check("mret_mstatus", 12'h300, 32'h1888);

    // trap beats a same-cycle mepc write; an unrelated write still lands
    trap_en = 1; trap_cause = 32'h2; trap_pc = 32'h400; trap_val = 32'h77;
    wr(12'h341, 32'h888);
    rd_check("trap_vs_wr_mepc", 12'h341, 32'h400);
    trap_pc = 32'h500;
    wr(12'h340, 32'h55);
    trap_en = 0;
    rd_check("trap_wr_mscratch", 12'h340, 32'h55);
    rd_check("trap_mtval", 12'h343, 32'h77);

    // counter carry and wrap
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h5);
    rd_check("mcycleh_wr", 12'hB80, 32'h5);
    rd_check("mcycle_carry", 12'hB00, 32'h0);
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'hFFFF_FFFF);
    rd_check("minstret_ones", 12'hB02, 32'hFFFF_FFFF);
    inst_retire = 1;
    tick();
    inst_retire = 0;
    rd_check("minstret_wrap", 12'hB02, 32'h0);
    rd_check("minstreth_wrap", 12'hB82, 32'h0);

    // illegal accesses
    csr_rd_addr = 12'h7C0;
    csr_wr_en = 1; csr_wr_addr = 12'hF14; csr_wr_data = 32'h7;
    #1;
    chk("ill_flag", 32'(csr_illegal), 32'h1);
    chk("ill_rd_zero", csr_rd_data, 32'h0);
    tick();
    csr_wr_en = 0;
    rd_check("ill_hartid", 12'hF14, HART_ID);

    // reset in the middle of activity
    rst = 1; trap_en = 1; trap_pc = 32'h900; mret_en = 1;
    wr(12'h340, 32'h1234);
    rst = 0; trap_en = 0; mret_en = 0;
    rd_check("mid_rst_mstatus", 12'h300, 32'h1800);
    rd_check("mid_rst_mscratch", 12'h340, 32'h0);
    rd_check("mid_rst_mepc", 12'h341, 32'h0);
    rd_check("mid_rst_mcycle", 12'hB00, 32'h0);

    // randomized run
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      csr_rd_addr = addr_pool[$urandom_range(0, 18)];
      csr_wr_en   = $urandom_range(0, 1);
      csr_wr_addr = addr_pool[$urandom_range(0, 18)];
      csr_wr_data = $urandom;
      inst_retire = $urandom_range(0, 1);
      trap_en     = ($urandom_range(0, 7) == 0);
      mret_en     = ($urandom_range(0, 7) == 0);
      trap_cause  = {1'($urandom_range(0, 1)), 26'b0, 5'($urandom_range(0, 31))};
      trap_pc     = $urandom;
      trap_val    = $urandom;
      ext_irq     = ($urandom_range(0, 3) == 0);
      timer_irq   = ($urandom_range(0, 3) == 0);
      sw_irq      = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
